// File: rtl/hud_stat_bank.sv
// Bank of saturating game-stat counters with edge-captured events, tick-driven decay,
// a tracked best value for channel 0 and active-low hex 7-segment readout.
module hud_stat_bank #(
  parameter int unsigned               NUM_CH       = 3,
  parameter int unsigned               WIDTH        = 8,
  parameter int unsigned               TICK_DIV     = 25_000_000,
  parameter logic [NUM_CH*WIDTH-1:0]   INIT_VALS    = (NUM_CH*WIDTH)'(24'hFF0000),
  parameter logic [NUM_CH-1:0]         AUTO_DN_MASK = NUM_CH'(3'b010)
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          run,
  input  logic [NUM_CH-1:0]             inc,
  input  logic [NUM_CH-1:0]             dec,
  input  logic [NUM_CH-1:0]             load,
  input  logic [NUM_CH*WIDTH-1:0]       load_val,
  input  logic                          best_clr,
  output logic [NUM_CH*WIDTH-1:0]       value,
  output logic [NUM_CH*(WIDTH/4)*7-1:0] seg,
  output logic [NUM_CH-1:0]             zero,
  output logic [NUM_CH-1:0]             full,
  output logic [WIDTH-1:0]              best,
  output logic [(WIDTH/4)*7-1:0]        best_seg,
  output logic                          tick
);

  localparam int unsigned DIGITS = WIDTH / 4;
  localparam int unsigned DivW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW     = WIDTH + 2;

  logic [NUM_CH-1:0]       inc_q, dec_q, load_q;
  logic [NUM_CH-1:0]       inc_evt, dec_evt, load_evt;
  logic [NUM_CH*WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0]        best_q, best_d;
  logic [DivW-1:0]         div_q, div_d;
  logic                    tick_q, tick_d;
  logic [WIDTH-1:0]        cur;
  logic [SW-1:0]           sum;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] g;
    unique case (h)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b1111100;
      4'hC: g = 7'b0111001;
      4'hD: g = 7'b1011110;
      4'hE: g = 7'b1111001;
      4'hF: g = 7'b1110001;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  always_comb begin
    inc_evt  = inc & ~inc_q;
    dec_evt  = dec & ~dec_q;
    load_evt = load & ~load_q;

    div_d  = div_q;
    tick_d = 1'b0;
    if (run) begin
      if (div_q == '0) begin
        div_d  = DivW'(TICK_DIV - 1);
        tick_d = 1'b1;
      end else begin
        div_d = div_q - DivW'(1);
      end
    end

    // Sum is WIDTH+2 bits: MSB flags underflow, bit WIDTH flags overflow.
    value_d = value_q;
    cur     = '0;
    sum     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cur = value_q[i*WIDTH +: WIDTH];
      sum = {2'b00, cur};
      if (inc_evt[i]) sum = sum + SW'(1);
      if (dec_evt[i]) sum = sum - SW'(1);
      if (tick_q && AUTO_DN_MASK[i]) sum = sum - SW'(1);
      if (load_evt[i]) begin
        value_d[i*WIDTH +: WIDTH] = load_val[i*WIDTH +: WIDTH];
      end else if (sum[SW-1]) begin
        value_d[i*WIDTH +: WIDTH] = '0;
      end else if (sum[WIDTH]) begin
        value_d[i*WIDTH +: WIDTH] = '1;
      end else begin
        value_d[i*WIDTH +: WIDTH] = sum[WIDTH-1:0];
      end
    end

    best_d = best_q;
    if (best_clr) begin
      best_d = '0;
    end else if (value_q[WIDTH-1:0] > best_q) begin
      best_d = value_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      inc_q   <= '0;
      dec_q   <= '0;
      load_q  <= '0;
      value_q <= INIT_VALS;
      best_q  <= '0;
      div_q   <= DivW'(TICK_DIV - 1);
      tick_q  <= 1'b0;
    end else begin
      inc_q   <= inc;
      dec_q   <= dec;
      load_q  <= load;
      value_q <= value_d;
      best_q  <= best_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    value    = value_q;
    best     = best_q;
    tick     = tick_q;
    zero     = '0;
    full     = '0;
    seg      = '0;
    best_seg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      zero[i] = (value_q[i*WIDTH +: WIDTH] == '0);
      full[i] = (value_q[i*WIDTH +: WIDTH] == '1);
      for (int d = 0; d < DIGITS; d++) begin
        seg[(i*DIGITS+d)*7 +: 7] = ~hex7(value_q[(i*DIGITS+d)*4 +: 4]);
      end
    end
    for (int d = 0; d < DIGITS; d++) begin
      best_seg[d*7 +: 7] = ~hex7(best_q[d*4 +: 4]);
    end
  end

endmodule

// File: tb/tb_hud_stat_bank.sv
// Self-checking bench for hud_stat_bank: directed vector table, decay/pause and
// same-cycle sequences, mid-operation reset, and randomized traffic against a model.
module tb_hud_stat_bank;

  localparam int          NC   = 3;
  localparam int          W    = 8;
  localparam int          TD   = 4;
  localparam int          DG   = 2;
  localparam logic [23:0] INIT = 24'h01_05_00;
  localparam logic [2:0]  MASK = 3'b010;

  logic          clock, resetn, run, best_clr;
  logic [2:0]    inc, dec, load;
  logic [23:0]   load_val;
  logic [23:0]   value;
  logic [41:0]   seg;
  logic [2:0]    zero, full;
  logic [7:0]    best;
  logic [13:0]   best_seg;
  logic          tick;

  hud_stat_bank #(
    .NUM_CH(NC), .WIDTH(W), .TICK_DIV(TD), .INIT_VALS(INIT), .AUTO_DN_MASK(MASK)
  ) dut (
    .clock(clock), .resetn(resetn), .run(run), .inc(inc), .dec(dec), .load(load),
    .load_val(load_val), .best_clr(best_clr), .value(value), .seg(seg), .zero(zero),
    .full(full), .best(best), .best_seg(best_seg), .tick(tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: plain integers, edge memory and a count of run cycles since reset.
  int          mval [NC];
  int          mbest;
  bit          mtick;
  bit          pi [NC], pd [NC], pl [NC];
  int          runcnt;
  logic [6:0]  glyph [16];
  logic [23:0] init_v;
  logic [2:0]  mask_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      mval[i] = int'(init_v[i*W +: W]);
      pi[i] = 0; pd[i] = 0; pl[i] = 0;
    end
    mbest = 0; mtick = 0; runcnt = 0;
  endtask

  task automatic model_step();
    int old0, n;
    bit ie, de, le;
    old0 = mval[0];
    for (int i = 0; i < NC; i++) begin
      ie = inc[i] && !pi[i];
      de = dec[i] && !pd[i];
      le = load[i] && !pl[i];
      if (le) begin
        mval[i] = int'(load_val[i*W +: W]);
      end else begin
        n = mval[i] + int'(ie) - int'(de) - ((mtick && mask_v[i]) ? 1 : 0);
        if (n < 0) n = 0;
        if (n > 255) n = 255;
        mval[i] = n;
      end
      pi[i] = inc[i]; pd[i] = dec[i]; pl[i] = load[i];
    end
    if (best_clr) mbest = 0;
    else if (old0 > mbest) mbest = old0;
    if (run) begin
      runcnt++;
      mtick = (runcnt % TD == 0);
    end else begin
      mtick = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [23:0] ev;
    logic [2:0]  ez, ef;
    logic [41:0] es;
    logic [13:0] eb;
    for (int i = 0; i < NC; i++) begin
      ev[i*W +: W] = mval[i][7:0];
      ez[i] = (mval[i] == 0);
      ef[i] = (mval[i] == 255);
      for (int d = 0; d < DG; d++) es[(i*DG+d)*7 +: 7] = ~glyph[(mval[i] >> (4*d)) & 15];
    end
    for (int d = 0; d < DG; d++) eb[d*7 +: 7] = ~glyph[(mbest >> (4*d)) & 15];
    chk({tag, "_value"}, 64'(value), 64'(ev));
    chk({tag, "_zero"}, 64'(zero), 64'(ez));
    chk({tag, "_full"}, 64'(full), 64'(ef));
    chk({tag, "_best"}, 64'(best), 64'(mbest));
    chk({tag, "_tick"}, 64'(tick), 64'(mtick));
    chk({tag, "_seg"}, 64'(seg), 64'(es));
    chk({tag, "_bseg"}, 64'(best_seg), 64'(eb));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    inc = '0; dec = '0; load = '0; load_val = '0; best_clr = 1'b0; run = 1'b0;
  endtask

  // Asserted between edges: state must drop to reset values without waiting for a clock.
  task automatic do_reset(input string tag);
    resetn = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  inc, dec, ld;
    logic [23:0] lv;
    logic        bclr;
    logic [23:0] ev;
    logic [7:0]  eb;
  } vec_t;

  vec_t tbl [18];

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    init_v = INIT;
    mask_v = MASK;

    tbl[0]  = '{3'b001, 3'b000, 3'b000, 24'h0, 1'b0, 24'h01_05_01, 8'h00};
    tbl[1]  = '{3'b001, 3'b000, 3'b000, 24'h0, 1'b0, 24'h01_05_01, 8'h01};
    tbl[2]  = '{3'b001, 3'b000, 3'b000, 24'h0, 1'b0, 24'h01_05_01, 8'h01};
    tbl[3]  = '{3'b001, 3'b000, 3'b000, 24'h0, 1'b0, 24'h01_05_01, 8'h01};
    tbl[4]  = '{3'b001, 3'b000, 3'b000, 24'h0, 1'b0, 24'h01_05_01, 8'h01};
    tbl[5]  = '{3'b000, 3'b100, 3'b000, 24'h0, 1'b0, 24'h00_05_01, 8'h01};
    tbl[6]  = '{3'b000, 3'b000, 3'b000, 24'h0, 1'b0, 24'h00_05_01, 8'h01};
    tbl[7]  = '{3'b000, 3'b100, 3'b000, 24'h0, 1'b0, 24'h00_05_01, 8'h01};
    tbl[8]  = '{3'b000, 3'b000, 3'b001, 24'h0000FE, 1'b0, 24'h00_05_FE, 8'h01};
    tbl[9]  = '{3'b001, 3'b000, 3'b000, 24'h0, 1'b0, 24'h00_05_FF, 8'hFE};
    tbl[10] = '{3'b000, 3'b000, 3'b000, 24'h0, 1'b0, 24'h00_05_FF, 8'hFF};
    tbl[11] = '{3'b001, 3'b000, 3'b000, 24'h0, 1'b0, 24'h00_05_FF, 8'hFF};
    tbl[12] = '{3'b000, 3'b000, 3'b000, 24'h0, 1'b1, 24'h00_05_FF, 8'h00};
    tbl[13] = '{3'b000, 3'b000, 3'b000, 24'h0, 1'b0, 24'h00_05_FF, 8'hFF};
    tbl[14] = '{3'b010, 3'b010, 3'b000, 24'h0, 1'b0, 24'h00_05_FF, 8'hFF};
    tbl[15] = '{3'b000, 3'b000, 3'b001, 24'h00003C, 1'b0, 24'h00_05_3C, 8'hFF};
    tbl[16] = '{3'b000, 3'b000, 3'b000, 24'h0, 1'b1, 24'h00_05_3C, 8'h00};
    tbl[17] = '{3'b000, 3'b000, 3'b000, 24'h0, 1'b0, 24'h00_05_3C, 8'h3C};

    idle_inputs();
    resetn = 1'b1;
    #2;
    do_reset("rst0");
    chk("rst_value", 64'(value), 64'(INIT));
    chk("rst_best", 64'(best), 64'h0);

    for (int r = 0; r < 18; r++) begin
      inc = tbl[r].inc; dec = tbl[r].dec; load = tbl[r].ld;
      load_val = tbl[r].lv; best_clr = tbl[r].bclr;
      step($sformatf("vec%0d", r));
      chk($sformatf("vec%0d_tbl_value", r), 64'(value), 64'(tbl[r].ev));
      chk($sformatf("vec%0d_tbl_best", r), 64'(best), 64'(tbl[r].eb));
      if (r == 5) chk("zero2", 64'(zero[2]), 64'h1);
      if (r == 9) chk("full0", 64'(full[0]), 64'h1);
      if (r == 15) chk("seg_3C", 64'(seg[13:0]), 64'({~7'b1001111, ~7'b0111001}));
      if (r == 16) chk("bseg_00", 64'(best_seg), 64'({~7'b0111111, ~7'b0111111}));
    end

    // Decay: ch1 from 3, tick every TD run cycles, pause freezes divider and value.
    idle_inputs();
    do_reset("rst1");
    load = 3'b010; load_val = 24'h00_03_00;
    step("dk_ld");
    load = '0;
    run = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step($sformatf("dk%0d", e));
      if (e == 4) chk("dk_tick4", 64'(tick), 64'h1);
      if (e == 5) chk("dk_ch1_2", 64'(value[15:8]), 64'h02);
    end
    run = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step($sformatf("pause%0d", e));
      chk($sformatf("pause%0d_tick", e), 64'(tick), 64'h0);
    end
    chk("pause_ch1", 64'(value[15:8]), 64'h02);
    run = 1'b1;
    for (int e = 7; e <= 18; e++) begin
      step($sformatf("dk%0d", e));
      if (e == 9)  chk("dk_ch1_1", 64'(value[15:8]), 64'h01);
      if (e == 13) chk("dk_ch1_0", 64'(value[15:8]), 64'h00);
      if (e == 17) chk("dk_ch1_sat0", 64'(value[15:8]), 64'h00);
    end

    // inc+dec+tick in one cycle, then load beating all three.
    idle_inputs();
    do_reset("rst2");
    run = 1'b1;
    for (int e = 1; e <= 4; e++) step($sformatf("sc%0d", e));
    chk("sc_tick", 64'(tick), 64'h1);
    inc = 3'b010; dec = 3'b010;
    step("sc_incdec");
    chk("sc_ch1_04", 64'(value[15:8]), 64'h04);
    inc = '0; dec = '0;
    for (int e = 6; e <= 8; e++) step($sformatf("sc%0d", e));
    chk("sc_tick2", 64'(tick), 64'h1);
    inc = 3'b010; dec = 3'b010; load = 3'b010; load_val = 24'h00_20_00;
    step("sc_load");
    chk("sc_ch1_20", 64'(value[15:8]), 64'h20);

    // Randomized traffic.
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NC; i++) begin
        inc[i]  = ($urandom_range(0, 2) == 0);
        dec[i]  = ($urandom_range(0, 2) == 0);
        load[i] = ($urandom_range(0, 9) == 0);
      end
      load_val = 24'($urandom);
      best_clr = ($urandom_range(0, 15) == 0);
      run      = ($urandom_range(0, 4) != 0);
      step($sformatf("rnd%0d", c));
    end

    // Reset mid-operation with inc held high: one count on the first edge after release.
    idle_inputs();
    inc = 3'b001;
    step("mid_pre");
    do_reset("mid_rst");
    chk("mid_rst_value", 64'(value), 64'(INIT));
    step("mid_post");
    chk("mid_ch0_1", 64'(value[7:0]), 64'h01);
    step("mid_hold");
    chk("mid_ch0_hold", 64'(value[7:0]), 64'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
